// File: rtl/fetch_stage.sv
// Instruction-fetch stage: launches one valid/ready read per PC, captures the response
// into the IF/ID register, holds it under decode stall and discards responses on redirect.
module fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        flush,
  input  logic        stall_in,
  output logic        pc_stall_out,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_misalign
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_RSP = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] DROP     = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        misalign;
  logic        can_issue;
  logic        req_fire;
  logic        mis_accept;
  logic        launch;

  assign misalign       = (pc_in[1:0] != 2'b00);
  assign can_issue      = (state == IDLE) && !reset && !flush && !stall_in;
  assign imem_req_valid = can_issue && !misalign;
  assign imem_addr      = pc_in;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign mis_accept     = can_issue && misalign;
  assign launch         = req_fire || mis_accept;
  // A flush must let pc_generator load the redirect target regardless of fetch state.
  assign pc_stall_out   = flush ? 1'b0 : !launch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pc_q           <= '0;
      hold_pc        <= '0;
      hold_instr     <= NOP_INSTR;
      if_id_valid    <= 1'b0;
      if_id_pc       <= '0;
      if_id_instr    <= NOP_INSTR;
      if_id_misalign <= 1'b0;
    end else if (flush) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
      if_id_misalign <= 1'b0;
      hold_pc        <= '0;
      hold_instr     <= NOP_INSTR;
      // A response arriving alongside the flush is the stale one; consume it here.
      case (state)
        WAIT_RSP: state <= imem_rsp_valid ? IDLE : DROP;
        DROP:     state <= imem_rsp_valid ? IDLE : DROP;
        default:  state <= IDLE;
      endcase
    end else begin
      if (!stall_in) begin
        if_id_valid    <= 1'b0;
        if_id_instr    <= NOP_INSTR;
        if_id_misalign <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (req_fire) begin
            pc_q  <= pc_in;
            state <= WAIT_RSP;
          end else if (mis_accept) begin
            if_id_valid    <= 1'b1;
            if_id_pc       <= pc_in;
            if_id_instr    <= NOP_INSTR;
            if_id_misalign <= 1'b1;
          end
        end
        WAIT_RSP: begin
          if (imem_rsp_valid) begin
            if (stall_in) begin
              hold_pc    <= pc_q;
              hold_instr <= imem_rsp_data;
              state      <= HOLD;
            end else begin
              if_id_valid    <= 1'b1;
              if_id_pc       <= pc_q;
              if_id_instr    <= imem_rsp_data;
              if_id_misalign <= 1'b0;
              state          <= IDLE;
            end
          end
        end
        HOLD: begin
          if (!stall_in) begin
            if_id_valid    <= 1'b1;
            if_id_pc       <= hold_pc;
            if_id_instr    <= hold_instr;
            if_id_misalign <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          if (imem_rsp_valid) state <= IDLE;
        end
      endcase
    end
  end

endmodule
